// File: rtl/bram_memory_dp.sv
// Simple dual-port synchronous RAM: one byte-enabled write port and one read
// port per cycle, a configurable read-during-write policy, an optional output
// register and a built-in zero-fill clear engine.
module bram_memory_dp #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    clr_start,
  output logic                    busy,
  output logic                    clr_done
);

  localparam int NB    = DATA_WIDTH / 8;
  // One extra bit so a full-depth clear reaches DEPTH-1 without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_clr_cnt;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  logic                  w_busy;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rd_in_range;
  logic                  w_rdw_hit;
  logic [DATA_WIDTH-1:0] w_be_mask;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_busy   = (r_state == S_CLEAR);
  assign busy     = w_busy;
  assign clr_done = (r_state == S_DONE);

  // Both ports are locked out while the clear engine owns the array.
  assign w_wr_acc      = wr_en & ~w_busy & ({1'b0, wr_addr} < CNT_W'(DEPTH));
  assign w_rd_acc      = rd_en & ~w_busy;
  assign w_rd_in_range = ({1'b0, rd_addr} < CNT_W'(DEPTH));
  assign w_rdw_hit     = w_wr_acc & (wr_addr == rd_addr);

  // Expand byte enables into a bit mask for the write-first bypass merge.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_be_mask
      assign w_be_mask[8*gi +: 8] = {8{wr_be[gi]}};
    end
  endgenerate

  assign w_rd_old    = r_mem[rd_addr];
  assign w_rd_merged = (w_rd_old & ~w_be_mask) | (wr_data & w_be_mask);
  assign w_rd_word   = !w_rd_in_range                 ? '0 :
                       (RDW_MODE == 1 && w_rdw_hit)   ? w_rd_merged :
                                                        w_rd_old;

  // Array write: clear engine zero-fill has priority, else byte-enabled write.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Clear FSM: IDLE -> CLEAR (DEPTH cycles, one word each) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clr_cnt <= '0;
          if (clr_start) begin
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_clr_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_clr_cnt <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // First read stage: registered array read; data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      // Optional output stage: one more cycle of latency, full throughput.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_valid = r_s2_valid;
      assign rd_data  = r_s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = r_s1_valid;
      assign rd_data  = r_s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_bram_memory_dp.sv
// Bench for bram_memory_dp: two instances share stimulus, one with read-old
// and latency 1, one with write-first bypass and the output register.
module tb_bram_memory_dp;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [15:0]  wr_be;
  logic [127:0] wr_data;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic         clr_start;

  logic [127:0] rd_data0, rd_data1;
  logic         rd_valid0, rd_valid1;
  logic         busy0, busy1;
  logic         clr_done0, clr_done1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bram_memory_dp #(.DATA_WIDTH(128), .ADDR_WIDTH(8), .DEPTH(256), .OUT_REG(0), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clr_start(clr_start), .busy(busy0), .clr_done(clr_done0));

  bram_memory_dp #(.DATA_WIDTH(128), .ADDR_WIDTH(8), .DEPTH(256), .OUT_REG(1), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clr_start(clr_start), .busy(busy1), .clr_done(clr_done1));

  typedef struct {
    logic         we;
    logic [7:0]   wa;
    logic [15:0]  be;
    logic [127:0] wd;
    logic         re;
    logic [7:0]   ra;
    logic [127:0] e0;
    logic [127:0] e1;
  } vec_t;

  localparam logic [127:0] D5  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] AAW = {16{8'hAA}};
  localparam logic [127:0] W55 = {16{8'h55}};
  localparam logic [127:0] BEM = 128'hAAAAAAAAAAAAAAAAAAAAAAAA55555555;
  localparam logic [127:0] TOPZ = 128'h00000000AAAAAAAAAAAAAAAA55555555;
  localparam logic [127:0] X9  = 128'hDEADBEEF0123456789ABCDEFFEEDC0DE;
  localparam logic [127:0] W200 = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [127:0] ONES = {128{1'b1}};

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] fill_word(input int a);
    logic [7:0] lo;
    lo = 8'(a);
    return {8'h5A, 112'd0, lo};
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
  endtask

  // One transaction: drive a cycle, then check dut0 after one edge and dut1
  // after two; dut0 must hold its data while dut1 catches up.
  task automatic op(input logic we, input logic [7:0] wa, input logic [15:0] be,
                    input logic [127:0] wd, input logic re, input logic [7:0] ra,
                    input logic [127:0] e0, input logic [127:0] e1, input string nm);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    @(negedge clk);
    idle_inputs();
    if (re) begin
      chk({nm, " dut0 valid"}, rd_valid0, 1'b1);
      chk({nm, " dut0 data"}, rd_data0, e0);
      chk({nm, " dut1 early valid"}, rd_valid1, 1'b0);
    end else begin
      chk({nm, " dut0 no valid"}, rd_valid0, 1'b0);
    end
    @(negedge clk);
    if (re) begin
      chk({nm, " dut1 valid"}, rd_valid1, 1'b1);
      chk({nm, " dut1 data"}, rd_data1, e1);
      chk({nm, " dut0 valid drop"}, rd_valid0, 1'b0);
      chk({nm, " dut0 hold"}, rd_data0, e0);
    end else begin
      chk({nm, " dut1 no valid"}, rd_valid1, 1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, " dut0 rd_data"}, rd_data0, '0);
    chk({nm, " dut0 rd_valid"}, rd_valid0, 1'b0);
    chk({nm, " dut0 busy"}, busy0, 1'b0);
    chk({nm, " dut0 clr_done"}, clr_done0, 1'b0);
    chk({nm, " dut1 rd_data"}, rd_data1, '0);
    chk({nm, " dut1 rd_valid"}, rd_valid1, 1'b0);
    chk({nm, " dut1 busy"}, busy1, 1'b0);
    chk({nm, " dut1 clr_done"}, clr_done1, 1'b0);
  endtask

  initial begin
    int busy_cnt0, busy_cnt1, done_cnt0, done_cnt1, stray;

    vecs[0]  = '{1'b1, 8'd5, 16'hFFFF, D5,   1'b0, 8'd0, '0,   '0};
    vecs[1]  = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd5, D5,   D5};
    vecs[2]  = '{1'b1, 8'd3, 16'hFFFF, AAW,  1'b0, 8'd0, '0,   '0};
    vecs[3]  = '{1'b1, 8'd3, 16'h000F, W55,  1'b0, 8'd0, '0,   '0};
    vecs[4]  = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd3, BEM,  BEM};
    vecs[5]  = '{1'b1, 8'd7, 16'hFFFF, 128'h1, 1'b0, 8'd0, '0, '0};
    vecs[6]  = '{1'b1, 8'd7, 16'hFFFF, 128'h2, 1'b1, 8'd7, 128'h1, 128'h2};
    vecs[7]  = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd7, 128'h2, 128'h2};
    vecs[8]  = '{1'b1, 8'd5, 16'h0000, ONES, 1'b1, 8'd5, D5,   D5};
    vecs[9]  = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd5, D5,   D5};
    vecs[10] = '{1'b1, 8'd9, 16'hFFFF, X9,   1'b1, 8'd3, BEM,  BEM};
    vecs[11] = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd9, X9,   X9};
    vecs[12] = '{1'b1, 8'd3, 16'hF000, '0,   1'b1, 8'd3, BEM,  TOPZ};
    vecs[13] = '{1'b0, 8'd0, 16'h0000, '0,   1'b1, 8'd3, TOPZ, TOPZ};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Directed vectors: latency, byte enables, read-during-write, hold.
    for (int v = 0; v < 14; v++) begin
      op(vecs[v].we, vecs[v].wa, vecs[v].be, vecs[v].wd, vecs[v].re, vecs[v].ra,
         vecs[v].e0, vecs[v].e1, $sformatf("vec%0d", v));
      $display("vec%0d we=%0b wa=%0d re=%0b ra=%0d dut0=%h dut1=%h", v, vecs[v].we,
               vecs[v].wa, vecs[v].re, vecs[v].ra, rd_data0, rd_data1);
    end

    // Back-to-back reads of 0..3 with no bubbles.
    for (int a = 0; a < 4; a++) op(1'b1, 8'(a), 16'hFFFF, fill_word(a), 1'b0, 8'd0, '0, '0, "b2b fill");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b dut0 valid c%0d", i), rd_valid0, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk($sformatf("b2b dut0 data c%0d", i), rd_data0, fill_word(i - 1));
      chk($sformatf("b2b dut1 valid c%0d", i), rd_valid1, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk($sformatf("b2b dut1 data c%0d", i), rd_data1, fill_word(i - 2));
      idle_inputs();
      if (i < 4) begin
        rd_en = 1'b1; rd_addr = 8'(i);
      end
    end
    $display("b2b reads 0..3 done");

    // Full clear with a concurrent write on the start cycle and traffic while busy.
    for (int a = 0; a < 256; a++) op(1'b1, 8'(a), 16'hFFFF, fill_word(a), 1'b0, 8'd0, '0, '0, "clr fill");
    @(negedge clk);
    clr_start = 1'b1; wr_en = 1'b1; wr_addr = 8'd4; wr_be = 16'hFFFF; wr_data = ONES;
    busy_cnt0 = 0; busy_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0; stray = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        chk("clear busy rise dut0", busy0, 1'b1);
        chk("clear busy rise dut1", busy1, 1'b1);
      end
      if (i == 5) begin
        wr_en = 1'b1; wr_addr = 8'd10; wr_be = 16'hFFFF; wr_data = ONES;
        rd_en = 1'b1; rd_addr = 8'd10; clr_start = 1'b1;
      end
      busy_cnt0 += int'(busy0); busy_cnt1 += int'(busy1);
      done_cnt0 += int'(clr_done0); done_cnt1 += int'(clr_done1);
      if (rd_valid0 || rd_valid1) stray++;
    end
    chk("clear busy cycles dut0", 128'(busy_cnt0), 128'd256);
    chk("clear busy cycles dut1", 128'(busy_cnt1), 128'd256);
    chk("clear done pulses dut0", 128'(done_cnt0), 128'd1);
    chk("clear done pulses dut1", 128'(done_cnt1), 128'd1);
    chk("clear stray rd_valid", 128'(stray), 128'd0);
    $display("clear busy0=%0d busy1=%0d done0=%0d done1=%0d stray=%0d",
             busy_cnt0, busy_cnt1, done_cnt0, done_cnt1, stray);
    for (int a = 0; a < 256; a++) op(1'b0, 8'd0, 16'h0, '0, 1'b1, 8'(a), '0, '0, $sformatf("cleared w%0d", a));

    // Reset in the middle of a clear.
    for (int a = 0; a < 16; a++) op(1'b1, 8'(a), 16'hFFFF, fill_word(a), 1'b0, 8'd0, '0, '0, "rst fill");
    op(1'b1, 8'd200, 16'hFFFF, W200, 1'b0, 8'd0, '0, '0, "rst fill200");
    op(1'b0, 8'd0, 16'h0, '0, 1'b1, 8'd200, W200, W200, "pre-rst read");
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst mid-clear");
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("rst held");
    rst = 1'b0;
    done_cnt0 = 0; done_cnt1 = 0; busy_cnt0 = 0; busy_cnt1 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      busy_cnt0 += int'(busy0); busy_cnt1 += int'(busy1);
      done_cnt0 += int'(clr_done0); done_cnt1 += int'(clr_done1);
    end
    chk("aborted clear busy", 128'(busy_cnt0 + busy_cnt1), 128'd0);
    chk("aborted clear done", 128'(done_cnt0 + done_cnt1), 128'd0);
    $display("rst mid-clear busy=%0d done=%0d", busy_cnt0 + busy_cnt1, done_cnt0 + done_cnt1);
    for (int a = 0; a < 10; a++) op(1'b0, 8'd0, 16'h0, '0, 1'b1, 8'(a), '0, '0, $sformatf("aborted w%0d", a));
    op(1'b0, 8'd0, 16'h0, '0, 1'b1, 8'd10, fill_word(10), fill_word(10), "aborted w10 kept");
    op(1'b0, 8'd0, 16'h0, '0, 1'b1, 8'd200, W200, W200, "aborted w200 kept");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
